// File: rtl/uart_program_loader.sv
// UART boot loader: receives a length-prefixed program over an 8N1 serial
// line and streams it as little-endian 32-bit words into instruction memory,
// holding the CPU in reset until the whole image has been written.
//
// Ports:
//   clock        system clock, all state on posedge
//   reset        asynchronous active-low reset
//   rx           UART serial input (idle high, asynchronous)
//   mem_we       one-cycle instruction memory write strobe
//   mem_addr     word address of the write (saturates at the top word)
//   mem_wdata    word being written
//   cpu_hold     high while the processor must stay in reset
//   busy         header started and load not yet complete
//   done         load complete, sticky until reset
//   frame_error  a stop bit was sampled low, sticky until reset
//   overflow     image longer than memory depth, sticky until reset
//   words_loaded number of words accepted so far
module uart_program_loader #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned ADDR_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  frame_error,
    output logic                  overflow,
    output logic [15:0]           words_loaded
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {LD_LEN_LO, LD_LEN_HI, LD_DATA, LD_DONE} ld_state_t;

    // ---------------- input synchronizer ----------------
    logic rx_meta, rx_sync;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // ---------------- receiver ----------------
    rx_state_t        rx_state, rx_next_state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             byte_valid, frame_pulse;
    logic             half_tick_c, full_tick_c;
    logic             cnt_clr_c, shift_en_c, byte_ok_c, frame_bad_c;

    assign half_tick_c = (clk_cnt == CNT_W'(HALF - 1));
    assign full_tick_c = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));

    // Receiver state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) rx_state <= RX_IDLE;
        else        rx_state <= rx_next_state;
    end

    // Receiver next state; a start bit that is high again at mid-bit is a glitch
    always_comb begin
        rx_next_state = rx_state;
        case (rx_state)
            RX_IDLE:  if (!rx_sync) rx_next_state = RX_START;
            RX_START: if (half_tick_c) rx_next_state = rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (full_tick_c && bit_cnt == 3'd7) rx_next_state = RX_STOP;
            RX_STOP:  if (full_tick_c) rx_next_state = RX_IDLE;
            default:  rx_next_state = RX_IDLE;
        endcase
    end

    // Receiver control strobes
    always_comb begin
        cnt_clr_c   = 1'b0;
        shift_en_c  = 1'b0;
        byte_ok_c   = 1'b0;
        frame_bad_c = 1'b0;
        case (rx_state)
            RX_IDLE:  cnt_clr_c = 1'b1;
            RX_START: cnt_clr_c = half_tick_c;
            RX_DATA: begin
                cnt_clr_c  = full_tick_c;
                shift_en_c = full_tick_c;
            end
            RX_STOP: begin
                cnt_clr_c   = full_tick_c;
                byte_ok_c   = full_tick_c && rx_sync;
                frame_bad_c = full_tick_c && !rx_sync;
            end
            default: cnt_clr_c = 1'b1;
        endcase
    end

    // Receiver datapath
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            clk_cnt     <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            byte_valid  <= 1'b0;
            frame_pulse <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            clk_cnt <= cnt_clr_c ? '0 : clk_cnt + CNT_W'(1);
            if (rx_state == RX_IDLE) bit_cnt <= '0;
            else if (shift_en_c)     bit_cnt <= bit_cnt + 3'd1;
            if (shift_en_c) shift_reg <= {rx_sync, shift_reg[7:1]};
            byte_valid  <= byte_ok_c;
            frame_pulse <= frame_bad_c;
            if (frame_bad_c) frame_error <= 1'b1;
        end
    end

    // ---------------- loader ----------------
    ld_state_t   ld_state, ld_next_state;
    logic [15:0] len_q;
    logic [1:0]  byte_idx;
    logic [23:0] word_q;
    logic        advance;
    logic        restart_c, last_word_c, in_range_c;
    logic        len_lo_en_c, len_hi_en_c, data_en_c;
    logic        hold_d, done_d, busy_d;

    assign restart_c   = frame_pulse && (ld_state != LD_DONE);
    assign last_word_c = ((words_loaded + 16'd1) == len_q);
    assign in_range_c  = ({1'b0, words_loaded} < DEPTH);

    // Loader state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ld_state <= LD_LEN_LO;
        else        ld_state <= ld_next_state;
    end

    // Loader next state; a framing error abandons the transfer unless already done
    always_comb begin
        ld_next_state = ld_state;
        case (ld_state)
            LD_LEN_LO: if (byte_valid) ld_next_state = LD_LEN_HI;
            LD_LEN_HI: if (byte_valid)
                ld_next_state = ({shift_reg, len_q[7:0]} == 16'd0) ? LD_DONE : LD_DATA;
            LD_DATA:   if (advance && last_word_c) ld_next_state = LD_DONE;
            LD_DONE:   ld_next_state = LD_DONE;
            default:   ld_next_state = LD_LEN_LO;
        endcase
        if (restart_c) ld_next_state = LD_LEN_LO;
    end

    // Loader outputs and enables; status flags follow the next state so they
    // change on the same edge as the state itself
    always_comb begin
        hold_d      = (ld_next_state != LD_DONE);
        done_d      = (ld_next_state == LD_DONE);
        busy_d      = (ld_next_state == LD_LEN_HI) || (ld_next_state == LD_DATA);
        len_lo_en_c = 1'b0;
        len_hi_en_c = 1'b0;
        data_en_c   = 1'b0;
        case (ld_state)
            LD_LEN_LO: len_lo_en_c = byte_valid;
            LD_LEN_HI: len_hi_en_c = byte_valid;
            LD_DATA:   data_en_c   = byte_valid;
            default:   ;
        endcase
    end

    // Loader datapath; the word counter/address advance one cycle after mem_we
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            busy         <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            overflow     <= 1'b0;
            words_loaded <= '0;
            len_q        <= '0;
            byte_idx     <= '0;
            word_q       <= '0;
            advance      <= 1'b0;
        end else begin
            cpu_hold <= hold_d;
            done     <= done_d;
            busy     <= busy_d;
            mem_we   <= 1'b0;
            if (restart_c) begin
                byte_idx <= '0;
                advance  <= 1'b0;
            end else begin
                if (len_lo_en_c) len_q[7:0] <= shift_reg;
                if (len_hi_en_c) begin
                    len_q[15:8]  <= shift_reg;
                    byte_idx     <= '0;
                    mem_addr     <= '0;
                    words_loaded <= '0;
                end
                if (data_en_c) begin
                    byte_idx <= byte_idx + 2'd1;
                    case (byte_idx)
                        2'd0: word_q[7:0]   <= shift_reg;
                        2'd1: word_q[15:8]  <= shift_reg;
                        2'd2: word_q[23:16] <= shift_reg;
                        default: begin
                            if (in_range_c) begin
                                mem_we    <= 1'b1;
                                mem_wdata <= {shift_reg, word_q};
                            end else begin
                                overflow  <= 1'b1;
                            end
                            advance <= 1'b1;
                        end
                    endcase
                end
                if (advance) begin
                    advance      <= 1'b0;
                    words_loaded <= words_loaded + 16'd1;
                    if (mem_addr != ADDR_MAX) mem_addr <= mem_addr + ADDR_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_program_loader.sv
// Self-checking bench for uart_program_loader: a table of serial bytes with
// the expected loader status after each, plus directed sequences for glitch
// rejection, memory overflow and reset in the middle of a word.
module tb_uart_program_loader;

    localparam int unsigned CPB = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        rx    = 1'b1;

    logic        mem_we, cpu_hold, busy, done, frame_error, overflow;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] words_loaded;

    logic        s_mem_we, s_cpu_hold, s_busy, s_done, s_frame_error, s_overflow;
    logic [1:0]  s_mem_addr;
    logic [31:0] s_mem_wdata;
    logic [15:0] s_words_loaded;

    always #5 clock = ~clock;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(8)) dut (
        .clock(clock), .reset(reset), .rx(rx),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done),
        .frame_error(frame_error), .overflow(overflow), .words_loaded(words_loaded)
    );

    uart_program_loader #(.CLKS_PER_BIT(CPB), .ADDR_WIDTH(2)) dut_s (
        .clock(clock), .reset(reset), .rx(rx),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .cpu_hold(s_cpu_hold), .busy(s_busy), .done(s_done),
        .frame_error(s_frame_error), .overflow(s_overflow), .words_loaded(s_words_loaded)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // Write logs, cleared while reset is asserted
    logic [7:0]  w_addr[$];
    logic [31:0] w_data[$];
    logic [7:0]  s_addr[$];
    logic [31:0] s_data[$];
    logic        prev_we = 1'b0;
    logic        s_prev_we = 1'b0;
    int          consec_err = 0;
    logic        hold_watch = 1'b0;
    int          hold_viol = 0;

    always @(negedge clock) begin
        if (!reset) begin
            w_addr.delete(); w_data.delete();
            s_addr.delete(); s_data.delete();
            prev_we = 1'b0; s_prev_we = 1'b0;
        end else begin
            if (mem_we) begin
                w_addr.push_back(mem_addr); w_data.push_back(mem_wdata);
                if (prev_we) consec_err++;
            end
            if (s_mem_we) begin
                s_addr.push_back(8'(s_mem_addr)); s_data.push_back(s_mem_wdata);
                if (s_prev_we) consec_err++;
            end
            prev_we = mem_we;
            s_prev_we = s_mem_we;
            if (hold_watch && !done && !cpu_hold) hold_viol++;
        end
    end

    typedef struct {
        logic        rst;
        logic [7:0]  b;
        logic        stop;
        logic        e_busy;
        logic        e_done;
        logic        e_hold;
        logic        e_ferr;
        int          e_words;
        int          e_writes;
        logic        chk_w;
        int          e_addr;
        logic [31:0] e_data;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [7:0] b, input logic stop,
                       input logic bz, input logic dn, input logic hd, input logic fe,
                       input int wd, input int wr,
                       input logic cw, input int ad, input logic [31:0] dt);
        vec_t v;
        v.rst = rst; v.b = b; v.stop = stop;
        v.e_busy = bz; v.e_done = dn; v.e_hold = hd; v.e_ferr = fe;
        v.e_words = wd; v.e_writes = wr;
        v.chk_w = cw; v.e_addr = ad; v.e_data = dt;
        tbl.push_back(v);
    endtask

    // One 8N1 frame followed by an idle bit and a short settle gap
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clock);
        end
        rx = stop;
        repeat (CPB) @(negedge clock);
        rx = 1'b1;
        repeat (CPB) @(negedge clock);
        repeat (4) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check("rst_async_hold", 32'(cpu_hold), 32'd1);
        check("rst_async_done", 32'(done), 32'd0);
        repeat (3) @(negedge clock);
        check("rst_we",    32'(mem_we), 32'd0);
        check("rst_addr",  32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_ferr",  32'(frame_error), 32'd0);
        check("rst_ovf",   32'(overflow), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_s_hold", 32'(s_cpu_hold), 32'd1);
        reset = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Two-word load, then a byte after done that must be ignored
        add(1, 8'h02, 1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        add(0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        add(0, 8'h13, 1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        add(0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        add(0, 8'h08, 1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        add(0, 8'h20, 1, 1, 0, 1, 0, 1, 1, 1, 0, 32'h20080013);
        add(0, 8'h14, 1, 1, 0, 1, 0, 1, 1, 0, 0, 32'h0);
        add(0, 8'h00, 1, 1, 0, 1, 0, 1, 1, 0, 0, 32'h0);
        add(0, 8'h09, 1, 1, 0, 1, 0, 1, 1, 0, 0, 32'h0);
        add(0, 8'h20, 1, 0, 1, 0, 0, 2, 2, 1, 1, 32'h20090014);
        add(0, 8'h55, 1, 0, 1, 0, 0, 2, 2, 0, 0, 32'h0);
        // Empty image
        add(1, 8'h00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        add(0, 8'h00, 1, 0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        // Framing error, then a fresh one-word load
        add(1, 8'h01, 1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        add(0, 8'h00, 1, 1, 0, 1, 0, 0, 0, 0, 0, 32'h0);
        add(0, 8'hAA, 0, 0, 0, 1, 1, 0, 0, 0, 0, 32'h0);
        add(0, 8'h01, 1, 1, 0, 1, 1, 0, 0, 0, 0, 32'h0);
        add(0, 8'h00, 1, 1, 0, 1, 1, 0, 0, 0, 0, 32'h0);
        add(0, 8'h11, 1, 1, 0, 1, 1, 0, 0, 0, 0, 32'h0);
        add(0, 8'h22, 1, 1, 0, 1, 1, 0, 0, 0, 0, 32'h0);
        add(0, 8'h33, 1, 1, 0, 1, 1, 0, 0, 0, 0, 32'h0);
        add(0, 8'h44, 1, 0, 1, 0, 1, 1, 1, 1, 0, 32'h44332211);

        @(negedge clock);
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].rst) do_reset();
            send_byte(tbl[i].b, tbl[i].stop);
            check($sformatf("v%0d_busy", i),   32'(busy), 32'(tbl[i].e_busy));
            check($sformatf("v%0d_done", i),   32'(done), 32'(tbl[i].e_done));
            check($sformatf("v%0d_hold", i),   32'(cpu_hold), 32'(tbl[i].e_hold));
            check($sformatf("v%0d_ferr", i),   32'(frame_error), 32'(tbl[i].e_ferr));
            check($sformatf("v%0d_ovf", i),    32'(overflow), 32'd0);
            check($sformatf("v%0d_words", i),  32'(words_loaded), 32'(tbl[i].e_words));
            check($sformatf("v%0d_writes", i), 32'(w_addr.size()), 32'(tbl[i].e_writes));
            if (tbl[i].chk_w) begin
                if (w_addr.size() == 0) begin
                    check($sformatf("v%0d_wlog", i), 32'd0, 32'd1);
                end else begin
                    check($sformatf("v%0d_waddr", i), 32'(w_addr[$]), 32'(tbl[i].e_addr));
                    check($sformatf("v%0d_wdata", i), w_data[$], tbl[i].e_data);
                end
            end
        end

        // Short low glitch on an idle line must not start a frame
        do_reset();
        rx = 1'b0;
        @(negedge clock);
        rx = 1'b1;
        repeat (20) @(negedge clock);
        check("glitch_busy",   32'(busy), 32'd0);
        check("glitch_done",   32'(done), 32'd0);
        check("glitch_hold",   32'(cpu_hold), 32'd1);
        check("glitch_ferr",   32'(frame_error), 32'd0);
        check("glitch_words",  32'(words_loaded), 32'd0);
        check("glitch_writes", 32'(w_addr.size()), 32'd0);
        send_byte(8'h00, 1'b1);
        check("glitch_hdr_busy", 32'(busy), 32'd1);
        send_byte(8'h00, 1'b1);
        check("glitch_hdr_done", 32'(done), 32'd1);
        check("glitch_hdr_hold", 32'(cpu_hold), 32'd0);

        // Five words into a four-word memory
        do_reset();
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i + 1), 1'b1);
            if (i == 15) begin
                check("ovf_mid_flag",   32'(s_overflow), 32'd0);
                check("ovf_mid_writes", 32'(s_addr.size()), 32'd4);
                check("ovf_mid_done",   32'(s_done), 32'd0);
            end
        end
        check("ovf_writes", 32'(s_addr.size()), 32'd4);
        for (int j = 0; j < 4; j++) begin
            logic [31:0] exp_w;
            exp_w = {8'(4 * j + 4), 8'(4 * j + 3), 8'(4 * j + 2), 8'(4 * j + 1)};
            if (j < s_addr.size()) begin
                check($sformatf("ovf_addr%0d", j), 32'(s_addr[j]), 32'(j));
                check($sformatf("ovf_data%0d", j), s_data[j], exp_w);
            end
        end
        check("ovf_flag",  32'(s_overflow), 32'd1);
        check("ovf_words", 32'(s_words_loaded), 32'd5);
        check("ovf_done",  32'(s_done), 32'd1);
        check("ovf_hold",  32'(s_cpu_hold), 32'd0);

        // Reset after two data bytes, then a clean one-word reload
        do_reset();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        check("midrst_pre_writes", 32'(w_addr.size()), 32'd0);
        check("midrst_pre_hold",   32'(cpu_hold), 32'd1);
        do_reset();
        hold_watch = 1'b1;
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'hEF, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hDE, 1'b1);
        hold_watch = 1'b0;
        check("midrst_writes", 32'(w_addr.size()), 32'd1);
        if (w_addr.size() > 0) begin
            check("midrst_addr", 32'(w_addr[0]), 32'd0);
            check("midrst_data", w_data[0], 32'hDEADBEEF);
        end
        check("midrst_done",      32'(done), 32'd1);
        check("midrst_hold",      32'(cpu_hold), 32'd0);
        check("midrst_hold_viol", 32'(hold_viol), 32'd0);

        check("we_back_to_back", 32'(consec_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_program_loader.md
Name: uart_program_loader

Overview:
Serial boot loader for the single-cycle MIPS core on the FPGA board. It receives a program over a UART line (8N1, LSB first) and assembles bytes into 32-bit words. It writes those words sequentially into the instruction memory write port. It holds the processor in reset until the load completes. It is the writer counterpart of the instruction memory's fetch (read) path.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200 baud); must be >= 4.
ADDR_WIDTH, 8, word-address width of the instruction memory (depth 2^ADDR_WIDTH words).

Ports:
clock  input  1  system clock; all state on posedge.
reset  input  1  asynchronous, active-low reset.
rx  input  1  UART serial input, idle high, asynchronous to clock.
mem_we  output  1  one-cycle instruction memory write strobe.
mem_addr  output  ADDR_WIDTH  word address for the write.
mem_wdata  output  32  word to write.
cpu_hold  output  1  high = processor must be held in reset.
busy  output  1  high once a header byte has been received and until DONE.
done  output  1  load complete; sticky until reset.
frame_error  output  1  stop bit sampled low; sticky until reset.
overflow  output  1  word count exceeded memory depth; sticky until reset.
words_loaded  output  16  count of words written, for the 7-segment displays.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0 except cpu_hold=1; both FSMs return to their idle/first state; synchronizer flops are set to 1.
- rx passes through a 2-flop synchronizer; all decisions use the synchronized value.
- Receiver FSM, states IDLE, START, DATA, STOP:
  - IDLE: a synchronized low moves to START and clears the bit counter.
  - START: at CLKS_PER_BIT/2 cycles, if rx is low go to DATA; otherwise treat it as a glitch and return to IDLE.
  - DATA: sample every CLKS_PER_BIT cycles; shift LSB first; go to STOP after 8 bits.
  - STOP: sample after CLKS_PER_BIT. If high, raise internal byte_valid for 1 cycle. If low, set frame_error, discard the byte, and reset the loader FSM to LEN_LO. Either way, return to IDLE.
- Loader FSM, states LEN_LO, LEN_HI, DATA, DONE; acts on byte_valid:
  - LEN_LO: byte becomes N[7:0]; set busy=1; go to LEN_HI.
  - LEN_HI: byte becomes N[15:8]. If N==0, go to DONE. Otherwise go to DATA with byte index 0 and mem_addr=0.
  - DATA: bytes are little-endian. Byte 0 goes to [7:0], byte 1 to [15:8], byte 2 to [23:16], byte 3 to [31:24].
    - On the 4th byte, the next cycle has mem_we=1 with mem_wdata holding the full word at the current mem_addr.
    - The following cycle, mem_addr increments and words_loaded increments.
    - When words_loaded reaches N, go to DONE.
    - If a word index is >= 2^ADDR_WIDTH, suppress mem_we and set overflow. words_loaded still counts, so the transfer stays framed. mem_addr does not wrap; it saturates at its maximum.
  - DONE: done=1, busy=0, cpu_hold=0. All further bytes are ignored. Only reset starts a new load.
- cpu_hold is 1 in every state except DONE, including after a frame error.
- mem_we is never high on two consecutive cycles.
- Write latency: mem_we rises exactly 1 cycle after the byte_valid of the 4th byte.
- Reset asserted mid-byte or mid-word: the partial word is discarded, nothing is written, and cpu_hold returns to 1 immediately.

Test Plan:
1. CLKS_PER_BIT=4; send 02 00, then 13 00 08 20, then 14 00 09 20. Required: mem_we at addr 0 with data 0x20080013, then at addr 1 with 0x20090014. words_loaded=2, done=1, cpu_hold=0.
2. Send header 00 00. Required: no mem_we pulse; done=1 and cpu_hold=0 after the second stop bit.
3. Send header 01 00, then byte AA with its stop bit forced low. Required: frame_error=1, no write, cpu_hold=1. A fresh header 01 00 followed by 4 valid bytes then writes addr 0.
4. rx low pulse of 1 cycle (shorter than CLKS_PER_BIT/2) while idle. Required: no byte_valid, state stays IDLE, all outputs unchanged.
5. ADDR_WIDTH=2; header 05 00 plus 20 bytes. Required: writes at addrs 0-3 only, overflow=1, words_loaded=5, done=1.
6. Assert reset after the 2nd data byte of word 0, then release and reload 1 word 0xDEADBEEF. Required: the first mem_we after reset is addr 0 with data 0xDEADBEEF; cpu_hold=1 throughout until done.
